// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with press/release debounce.
// Drives one column low at a time and reports {col,row} with a one-clk valid strobe.
module keypad_scan #(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scan_en,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);
   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
   state_t     r_state;
   logic [1:0] r_col, r_row;
   logic [3:0] r_cnt, r_sync1, r_sync2;
   logic       w_any, w_hit, w_last;
   logic [1:0] w_win;
   assign col_n  = ~(4'b1000 >> r_col);
   assign w_any  = ~&r_sync2;
   // row r lives on bit 3-r, which is ~r for a 2-bit index; lowest r wins
   assign w_win  = !r_sync2[3] ? 2'd0 : !r_sync2[2] ? 2'd1 : !r_sync2[1] ? 2'd2 : 2'd3;
   assign w_hit  = ~r_sync2[~r_row];
   assign w_last = (r_cnt + 4'd1) == 4'(DEBOUNCE_SCANS);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= SCAN;
         r_col     <= 2'd0;
         r_row     <= 2'd0;
         r_cnt     <= 4'd0;
         r_sync1   <= 4'hF;
         r_sync2   <= 4'hF;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_down  <= 1'b0;
      end else begin
         r_sync1   <= row_n;
         r_sync2   <= r_sync1;
         key_valid <= 1'b0;
         if (scan_en) begin
            case (r_state)
               SCAN:
                  if (w_any) begin
                     r_row   <= w_win;
                     r_cnt   <= 4'd1;
                     r_state <= DEBOUNCE;
                  end else r_col <= r_col + 2'd1;
               DEBOUNCE:
                  if (!w_hit) begin
                     r_cnt   <= 4'd0;
                     r_col   <= r_col + 2'd1;
                     r_state <= SCAN;
                  end else if (w_last) begin
                     key_code  <= {r_col, r_row};
                     key_valid <= 1'b1;
                     key_down  <= 1'b1;
                     r_cnt     <= 4'd0;
                     r_state   <= HELD;
                  end else r_cnt <= r_cnt + 4'd1;
               HELD:
                  if (!w_hit) begin
                     r_cnt   <= 4'd1;
                     r_state <= RELEASE;
                  end
               RELEASE:
                  if (w_hit) begin
                     r_cnt   <= 4'd0;
                     r_state <= HELD;
                  end else if (w_last) begin
                     key_down <= 1'b0;
                     r_col    <= r_col + 2'd1;
                     r_cnt    <= 4'd0;
                     r_state  <= SCAN;
                  end else r_cnt <= r_cnt + 4'd1;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed checks of keypad_scan against a simple key-matrix model.
module tb_keypad_scan;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_en = 1'b0;
   logic [3:0]  row_n, col_n, key_code;
   logic        key_valid, key_down;
   logic [15:0] keys = 16'h0;
   int          total = 0, fails = 0, vcount = 0;

   keypad_scan #(.DEBOUNCE_SCANS(4)) dut (
      .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .row_n(row_n),
      .col_n(col_n), .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
   );

   always #5 clk = ~clk;

   // keys[c*4+r] pressed pulls row r low while column c is driven
   always_comb begin
      row_n = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[c*4+r] && !col_n[3-c]) row_n[3-r] = 1'b0;
   end

   always @(negedge clk) if (key_valid) vcount = vcount + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         repeat (3) @(negedge clk);
         scan_en = 1'b1;
         @(negedge clk);
         scan_en = 1'b0;
         #1;
      end
   endtask

   logic [3:0] colpat [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   initial begin
      #2;
      chk("rst_col", col_n, 4'b0111);
      chk("rst_code", key_code, 4'd0);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_down", key_down, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick(1);
         chk($sformatf("scan_col%0d", i), col_n, colpat[i%4]);
      end
      chk("scan_novalid", vcount, 0);
      // press col2/row1 -> code 9
      keys = 16'h0200;
      tick(5);
      chk("pre_accept_down", key_down, 1'b0);
      chk("pre_accept_valid", vcount, 0);
      tick(1);
      chk("accept_code", key_code, 4'd9);
      chk("accept_down", key_down, 1'b1);
      chk("accept_valid", vcount, 1);
      chk("accept_col", col_n, 4'b1101);
      tick(2);
      chk("held_col", col_n, 4'b1101);
      chk("held_down", key_down, 1'b1);
      chk("held_valid", vcount, 1);
      // release glitch of one tick
      keys = 16'h0;
      tick(1);
      keys = 16'h0200;
      tick(1);
      chk("relglitch_down", key_down, 1'b1);
      chk("relglitch_valid", vcount, 1);
      keys = 16'h0;
      tick(3);
      chk("rel3_down", key_down, 1'b1);
      tick(1);
      chk("rel_down", key_down, 1'b0);
      chk("rel_col", col_n, 4'b1110);
      chk("rel_code", key_code, 4'd9);
      // bounce: two low samples then high
      keys = 16'h0200;
      tick(5);
      keys = 16'h0;
      tick(1);
      chk("bounce_valid", vcount, 1);
      chk("bounce_code", key_code, 4'd9);
      chk("bounce_down", key_down, 1'b0);
      chk("bounce_col", col_n, 4'b1110);
      // col1 rows 0 and 2 -> lowest row wins, code 4
      keys = 16'h0050;
      tick(6);
      chk("multi_code", key_code, 4'd4);
      chk("multi_valid", vcount, 2);
      chk("multi_down", key_down, 1'b1);
      keys = 16'h0;
      tick(4);
      chk("multi_rel_down", key_down, 1'b0);
      chk("multi_rel_col", col_n, 4'b1101);
      // reset during debounce with cnt=2
      keys = 16'h0200;
      tick(2);
      chk("mid_deb_down", key_down, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_col", col_n, 4'b0111);
      chk("arst_code", key_code, 4'd0);
      chk("arst_valid", key_valid, 1'b0);
      chk("arst_down", key_down, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick(5);
      chk("redet_pre_valid", vcount, 2);
      chk("redet_pre_down", key_down, 1'b0);
      tick(1);
      chk("redet_code", key_code, 4'd9);
      chk("redet_down", key_down, 1'b1);
      chk("redet_valid", vcount, 3);
      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanning controller for a 4x4 matrix keypad: the input-side counterpart of the four-digit 7-segment scan controller. It drives one keypad column low at a time, samples the four row lines, debounces press and release over a programmable number of scan ticks, and reports a 4-bit key code with a one-cycle valid strobe. It sits between the board keypad pins and the counter/display logic. It uses the same divided scan tick as the display so both share one frequency divider.

## Interface
- DEBOUNCE_SCANS, 4: consecutive consistent scan ticks required to accept a press or a release; legal range 2..15.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- scan_en  input  1  one-clk-wide scan tick from the frequency divider; period ≥ 4 clk.
- row_n  input  4  keypad rows, active-low, asynchronous to clk (pulled up off-chip).
- col_n  output  4  keypad column drive, active-low, exactly one bit low at all times.
- key_code  output  4  last accepted key, {col_idx[1:0], row_idx[1:0]}.
- key_valid  output  1  one-clk pulse when a debounced press is accepted.
- key_down  output  1  level; high while the accepted key is held.

## Operation
- Column index c (2 bits) drives col_n: c=0 -> 4'b0111, 1 -> 4'b1011, 2 -> 4'b1101, 3 -> 4'b1110.
- Row r is read on row_n[3-r]. row_n passes through a 2-FF synchronizer (reset value 4'b1111) before any use.
- Multiple rows low in the scanned column: the lowest r wins. A different column is never examined while a key is latched.
- A 4-bit debounce counter cnt.
- FSM states:
  - SCAN: on scan_en, if any synchronized row is low, latch c and the winning r, set cnt=1, go to DEBOUNCE. Otherwise c <= c+1 (wraps 3 -> 0).
  - DEBOUNCE: c frozen. On scan_en, if the latched row is low, cnt++. When cnt+1 == DEBOUNCE_SCANS: update key_code, pulse key_valid, set key_down=1, go to HELD. If the latched row is high, cnt=0, c <= c+1, go to SCAN.
  - HELD: c frozen. On scan_en, if the latched row is high, set cnt=1 and go to RELEASE. Otherwise stay.
  - RELEASE: on scan_en, if the latched row is high, cnt++. When cnt+1 == DEBOUNCE_SCANS: key_down=0, c <= c+1, go to SCAN. If the latched row is low, cnt=0, go back to HELD with no new key_valid.
- Other rows changing while a key is latched are ignored.
- key_code holds its value until the next accepted press. It is not cleared on release.
- Nothing happens between scan_en pulses apart from synchronizer shifting.

## Timing
- Reset (asynchronous, immediate): state=SCAN, c=0, col_n=4'b0111, cnt=0, key_code=4'd0, key_valid=0, key_down=0, synchronizer=4'b1111.
- col_n changes only in the clk after a scan_en edge. Rows sampled at a scan_en therefore reflect a column that has been stable for ≥ 3 clk, which the period rule (≥ 4 clk) guarantees.
- Row input to synchronized value: 2 clk.
- Press acceptance: key_valid, key_code and the key_down rise are registered. They appear in the clk following the DEBOUNCE_SCANS-th consecutive low sample, the first being the detection sample in SCAN.
- key_valid is high for exactly 1 clk per accepted press, never during release or while held.
- key_down falls in the clk following the DEBOUNCE_SCANS-th consecutive high sample, the first being the sample that entered RELEASE.
- Reset asserted in any state aborts the operation. No key_valid is issued after rst_n deasserts unless a fresh full debounce completes.

## Test plan
- Reset, no keys, 8 scan_en pulses -> col_n sequence 0111, 1011, 1101, 1110, 0111, ... and key_valid never asserts; all outputs 0 after reset.
- Press col 2 / row 1 (row_n=4'b1011 while col_n=1101), held -> after 4 consistent ticks key_code=4'd9, one key_valid pulse, key_down=1, col_n stays 1101 while held.
- Bounce: row low for 2 ticks, then high -> no key_valid, key_code unchanged, scanning resumes at col_n=1110.
- Release: held key, rows go high for 1 tick then low -> stays HELD, no second key_valid. Rows then high for 4 ticks -> key_down=0 and scanning resumes at the next column.
- Rows 0 and 2 low together in col 1 -> key_code=4'd4.
- rst_n pulsed low mid-DEBOUNCE (cnt=2) -> col_n=0111 and outputs 0 immediately. After release, the held key is re-detected only after 4 fresh consistent ticks.
